eoc_group: RTL and testbench
============================

# eoc_group

Synchronous, parametrised end-of-column readout for a group of `NCOL` pixel columns. It replaces per-column asynchronous token/freeze logic with one clocked state machine. Each readout frame snapshots the enabled column tokens and reads the frozen columns in lowest-index-first order, re-reading a column while its token stays high. Address-tagged words go into a small FIFO with a valid/ready output. The block sits at the bottom of the matrix between the column drains and the chip-level serialiser, and it chains with neighbouring groups through the chip token.

## Interface
Parameters:
- `NCOL`, 4: columns in the group (1–32).
- `ADDR_BASE`, 0: address of column 0; column i reports `(ADDR_BASE+i) mod 2^ADDR_W`.
- `ADDR_W`, 6: column address width.
- `DATA_W`, 21: column data word width.
- `BCID_W`, 6: BCID width.
- `FIFO_DEPTH`, 4: output FIFO depth, power of two, ≥2.

Ports:
- `Clk`  in  1  clock; all state on the rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Freeze`  in  1  frame request; a rising edge starts a frame.
- `TokInChip`  in  1  upstream token; high means an upstream group has priority.
- `TokOutChip`  out  1  `TokInChip | (|(TokInCol & ColEnable)) | (|frozen)`; combinational.
- `TokInCol`  in  NCOL  per-column hit-pending token.
- `ColEnable`  in  NCOL  per-column enable.
- `ReadCol`  out  NCOL  one-hot, one-cycle column read strobe.
- `ColData`  in  NCOL*DATA_W  column data; column i occupies bits `[i*DATA_W +: DATA_W]`.
- `Bcid`  in  BCID_W  BCID.
- `BcidCol`  out  NCOL*BCID_W  `Bcid` for each enabled column, 0 for disabled columns; combinational.
- `DataOut`  out  ADDR_W+DATA_W  FIFO head word `{addr, data}`.
- `DataValid`  out  1  FIFO not empty.
- `DataReady`  in  1  consumer accept.
- `Busy`  out  1  frame in progress (state ≠ IDLE).

## Operation
- Freeze edge detection:
  - `Freeze` is registered into `freeze_d`; a rise is `Freeze & !freeze_d`.
  - A rise is accepted only in IDLE; rises in any other state are ignored.
- States:
  - IDLE: on an accepted rise, `frozen <= TokInCol & ColEnable`; if the result is nonzero go to SCAN, otherwise stay in IDLE.
  - SCAN:
    - First clear every `frozen` bit whose `ColEnable` is low.
    - If `frozen == 0`, go to IDLE.
    - Otherwise select i = lowest set bit. Go to READ only when `TokInChip == 0` and the FIFO count is less than `FIFO_DEPTH`; else stall in SCAN.
  - READ: `ReadCol[i] = 1` for exactly this cycle; go to LATCH.
  - LATCH: push `{ADDR_BASE+i, ColData[i]}` into the FIFO; go to CHECK.
  - CHECK:
    - If `TokInCol[i] & ColEnable[i]`, keep `frozen[i]` set, so the column is read again.
    - Otherwise clear `frozen[i]`.
    - Go to SCAN.
- Priority is fixed by index: a column stays selected until its bit clears, and higher indices wait.
- Columns that raise their token after the snapshot are not read in this frame; they are picked up by the next frame.
- FIFO behaviour:
  - Pop when `DataValid & DataReady`.
  - A simultaneous push and pop leaves the count unchanged.
  - It cannot overflow, because READ requires free space and only one word is ever outstanding.
- Address arithmetic is `ADDR_W`-bit and wraps.

## Timing
- Reset values:
  - `ReadCol = 0`, `frozen = 0`, `freeze_d = 0`.
  - FIFO empty, so `DataValid = 0` and `DataOut = 0`.
  - `Busy = 0`, state IDLE.
- During reset, `TokOutChip = TokInChip | (|(TokInCol & ColEnable))`.
- An asserted `Rst` mid-frame aborts the frame: `ReadCol` drops immediately (asynchronously) and the FIFO contents are discarded.
- Latency:
  - Accepted rise at edge t gives SCAN from t+1 and the first `ReadCol` in cycle t+2.
  - Column data must be valid in the cycle after `ReadCol`; it is sampled at the end of LATCH.
  - The word appears on `DataOut` one cycle after LATCH if the FIFO was empty.
- Throughput is at most one word every 4 cycles (SCAN, READ, LATCH, CHECK).
- `TokInCol[i]` is sampled in CHECK, two cycles after the strobe, so the column has one full cycle to update its token.
- `Busy` is high from the cycle after an accepted rise until the return to IDLE.

## Test plan
- Reset check: assert `Rst` with `Freeze=1` and `TokInCol=4'b1111`. All outputs hold the reset values. After release, exactly one frame starts.
- Two-column frame (NCOL=4, ADDR_BASE=8):
  - Stimulus: `TokInCol=4'b1010`, each token dropped after one read, col1 data `0x00AAA`, col3 data `0x00BBB`, `DataReady=1`, Freeze rise.
  - Required: `ReadCol=4'b0010`, then `4'b1000` four cycles later; `DataOut` gives `{9,0x00AAA}` then `{11,0x00BBB}`; `Busy` falls after the second CHECK.
- Multi-hit column: col0 token held for 3 reads → three consecutive strobes on col0 only, each with address `ADDR_BASE`; col2 (also frozen) is read only afterwards.
- Backpressure:
  - Stimulus: `FIFO_DEPTH=4`, `DataReady=0`, six reads pending.
  - Required: exactly 4 strobes, then the block stalls in SCAN with `ReadCol=0` and `Busy=1`.
  - Raise `DataReady`: all 6 words come out in order with no loss or duplicate.
- Chain priority: `TokInChip=1` during a frame → no strobes and `TokOutChip=1`. After it drops, reading resumes within 2 cycles.
- Mid-frame disable and late token:
  - Clear `ColEnable[3]` while `frozen[3]` is set → col3 is never strobed.
  - A token raised on col2 after the snapshot is not read until the next Freeze rise.
  - A Freeze rise during `Busy` is ignored.

Source files
------------

// File: rtl/eoc_group.sv
// eoc_group: clocked end-of-column readout for a group of pixel columns with an address-tagged output FIFO
module eoc_group #(
  parameter int NCOL       = 4,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 21,
  parameter int BCID_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Freeze,
  input  logic                     TokInChip,
  output logic                     TokOutChip,
  input  logic [NCOL-1:0]          TokInCol,
  input  logic [NCOL-1:0]          ColEnable,
  output logic [NCOL-1:0]          ReadCol,
  input  logic [NCOL*DATA_W-1:0]   ColData,
  input  logic [BCID_W-1:0]        Bcid,
  output logic [NCOL*BCID_W-1:0]   BcidCol,
  output logic [ADDR_W+DATA_W-1:0] DataOut,
  output logic                     DataValid,
  input  logic                     DataReady,
  output logic                     Busy
);
  localparam int SW = NCOL > 1 ? $clog2(NCOL) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int WW = ADDR_W + DATA_W;
  typedef enum logic [2:0] {IDLE, SCAN, READ, LATCH, CHECK} state_t;
  state_t state_q, state_d;
  logic [NCOL-1:0] frozen_q, frozen_d, read_col_q, read_col_d, live;
  logic [SW-1:0] sel_q, sel_d, low;
  logic freeze_prev_q;
  logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] col_word;
  logic [ADDR_W-1:0] addr;
  logic rise, push, pop;
  assign rise = Freeze & ~freeze_prev_q;
  assign push = state_q == LATCH;
  assign pop = DataValid & DataReady;
  assign addr = ADDR_W'(ADDR_BASE) + ADDR_W'(sel_q);
  assign DataValid = cnt_q != '0;
  assign DataOut = DataValid ? mem_q[rd_q] : '0;
  assign Busy = state_q != IDLE;
  assign ReadCol = read_col_q;
  assign TokOutChip = TokInChip | (|(TokInCol & ColEnable)) | (|frozen_q);
  for (genvar g = 0; g < NCOL; g++) begin : g_bcid
    assign BcidCol[g*BCID_W +: BCID_W] = ColEnable[g] ? Bcid : '0;
  end
  // still-enabled frozen columns, the lowest one of them, and the data of the selected column
  always_comb begin
    live = frozen_q & ColEnable;
    low = '0;
    col_word = '0;
    for (int k = NCOL - 1; k >= 0; k--) if (live[k]) low = SW'(k);
    for (int k = 0; k < NCOL; k++) if (SW'(k) == sel_q) col_word = ColData[k*DATA_W +: DATA_W];
  end
  // frame sequencing: snapshot, pick lowest column, strobe, latch, decide on a re-read
  always_comb begin
    state_d = state_q;
    frozen_d = frozen_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (rise) begin
        frozen_d = TokInCol & ColEnable;
        state_d = |(TokInCol & ColEnable) ? SCAN : IDLE;
      end
      SCAN: begin
        frozen_d = live;
        sel_d = low;
        state_d = live == '0 ? IDLE : (!TokInChip && cnt_q < CW'(FIFO_DEPTH)) ? READ : SCAN;
      end
      READ: state_d = LATCH;
      LATCH: state_d = CHECK;
      CHECK: begin
        frozen_d[sel_q] = TokInCol[sel_q] & ColEnable[sel_q];
        state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
    read_col_d = state_d == READ ? NCOL'(1) << sel_d : '0;
  end
  // fifo pointer and occupancy bookkeeping; a push and pop together leave the count unchanged
  always_comb begin
    wr_d = wr_q + FW'(push);
    rd_d = rd_q + FW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // control state; reset aborts a frame, drops the strobe at once and empties the fifo
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q <= IDLE;
      frozen_q <= '0;
      sel_q <= '0;
      read_col_q <= '0;
      freeze_prev_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      frozen_q <= frozen_d;
      sel_q <= sel_d;
      read_col_q <= read_col_d;
      freeze_prev_q <= Freeze;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // fifo storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge Clk)
    if (push) mem_q[wr_q] <= {addr, col_word};
endmodule

// File: tb/tb_eoc_group.sv
// tb_eoc_group: randomized scoreboard bench for eoc_group with a column behaviour model
module tb_eoc_group;
  localparam int NCOL = 4, AB = 8, AW = 6, DW = 21, BW = 6, FD = 4;
  logic clk = 0, Rst = 1, Freeze = 0, TokInChip = 0, DataReady = 0;
  logic TokOutChip, DataValid, Busy;
  logic [NCOL-1:0] TokInCol = '0, ColEnable = '0, ReadCol;
  logic [NCOL*DW-1:0] ColData = '0;
  logic [BW-1:0] Bcid = '0;
  logic [NCOL*BW-1:0] BcidCol;
  logic [AW+DW-1:0] DataOut;
  int n_cmp = 0, n_bad = 0, gap = 0;
  int h[NCOL], idx[NCOL];
  logic [DW-1:0] dat[NCOL][4];
  int exp_s[$], got_s[$];
  logic [AW+DW-1:0] sb[$];
  bit rnd_ready = 0;

  eoc_group #(.NCOL(NCOL), .ADDR_BASE(AB), .ADDR_W(AW), .DATA_W(DW), .BCID_W(BW), .FIFO_DEPTH(FD)) dut (
    .Clk(clk), .Rst(Rst), .Freeze(Freeze), .TokInChip(TokInChip), .TokOutChip(TokOutChip),
    .TokInCol(TokInCol), .ColEnable(ColEnable), .ReadCol(ReadCol), .ColData(ColData),
    .Bcid(Bcid), .BcidCol(BcidCol), .DataOut(DataOut), .DataValid(DataValid),
    .DataReady(DataReady), .Busy(Busy));

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!Rst && DataValid && DataReady) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dataout_extra: got %0h expected no word", DataOut);
      end else check("dataout", 64'(DataOut), 64'(sb.pop_front()));
    end

  task automatic upd();
    for (int i = 0; i < NCOL; i++) TokInCol[i] = h[i] > 0;
  endtask

  task automatic cyc();
    int c;
    @(posedge clk);
    #1;
    if (rnd_ready) DataReady = $urandom_range(0, 3) != 0;
    if (ReadCol != '0) begin
      c = -1;
      gap = 0;
      if ($countones(ReadCol) == 1) for (int i = 0; i < NCOL; i++) if (ReadCol[i]) c = i;
      got_s.push_back(c);
      if (c >= 0 && h[c] > 0) begin
        ColData[c*DW +: DW] = dat[c][idx[c]];
        idx[c]++;
        h[c]--;
      end
    end else gap++;
    upd();
  endtask

  task automatic snap_expect(input logic [NCOL-1:0] mask);
    exp_s.delete();
    got_s.delete();
    for (int i = 0; i < NCOL; i++) begin
      idx[i] = 0;
      for (int k = 0; k < h[i]; k++) dat[i][k] = DW'($urandom);
      if (h[i] > 0 && ColEnable[i] && mask[i])
        for (int k = 0; k < h[i]; k++) begin
          exp_s.push_back(i);
          sb.push_back({AW'(AB + i), dat[i][k]});
        end
    end
  endtask

  task automatic start_frame(input logic [NCOL-1:0] mask, input bit lat);
    int occ, low;
    logic [NCOL-1:0] s;
    logic [NCOL*BW-1:0] eb;
    occ = sb.size();
    upd();
    s = TokInCol & ColEnable;
    low = 0;
    for (int i = NCOL - 1; i >= 0; i--) if (s[i]) low = i;
    Bcid = BW'($urandom);
    for (int i = 0; i < NCOL; i++) eb[i*BW +: BW] = ColEnable[i] ? Bcid : '0;
    #1;
    check("bcidcol", 64'(BcidCol), 64'(eb));
    snap_expect(mask);
    Freeze = 1;
    cyc();
    check("busy_after_rise", 64'(Busy), 64'(s != '0));
    check("no_strobe_first_cycle", 64'(ReadCol), 0);
    if (lat && s != '0 && occ < FD && !TokInChip) begin
      cyc();
      check("first_strobe", 64'(ReadCol), 64'(1 << low));
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (Busy && n < limit) begin
      cyc();
      n++;
    end
    check("frame_done", 64'(Busy), 0);
    if (got_s.size() > 0) check("busy_fall_gap", 64'(gap), 4);
  endtask

  task automatic cmp_strobes();
    check("strobe_count", 64'(got_s.size()), 64'(exp_s.size()));
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) check("strobe_col", 64'(got_s[i]), 64'(exp_s[i]));
  endtask

  task automatic drain();
    int n = 0;
    rnd_ready = 0;
    DataReady = 1;
    while (sb.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    check("drain", 64'(sb.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < NCOL; i++) begin
      h[i] = 1;
      idx[i] = 0;
    end
    ColEnable = 4'hF;
    Freeze = 1;
    Bcid = 6'h2d;
    upd();
    repeat (3) cyc();
    check("rst_readcol", 64'(ReadCol), 0);
    check("rst_valid", 64'(DataValid), 0);
    check("rst_dataout", 64'(DataOut), 0);
    check("rst_busy", 64'(Busy), 0);
    check("rst_tokout", 64'(TokOutChip), 1);
    ColEnable = 4'b0101;
    #1;
    check("bcidcol_mask", 64'(BcidCol), 64'({6'd0, Bcid, 6'd0, Bcid}));
    ColEnable = 4'b0000;
    #1;
    check("rst_tokout_off", 64'(TokOutChip), 0);
    ColEnable = 4'hF;
    DataReady = 1;
    Rst = 0;
    start_frame(4'hF, 1);
    wait_idle(100);
    cmp_strobes();
    repeat (5) cyc();
    check("one_frame_only", 64'(Busy), 0);
    Freeze = 0;
    cyc();

    drain();
    h = '{2, 0, 1, 0};
    TokInChip = 1;
    start_frame(4'hF, 0);
    repeat (8) cyc();
    check("chain_no_strobe", 64'(got_s.size()), 0);
    check("chain_tokout", 64'(TokOutChip), 1);
    check("chain_busy", 64'(Busy), 1);
    TokInChip = 0;
    cyc();
    cyc();
    check("chain_resume", 64'(got_s.size() != 0), 1);
    wait_idle(100);
    cmp_strobes();
    Freeze = 0;
    cyc();

    drain();
    DataReady = 0;
    h = '{3, 0, 3, 0};
    start_frame(4'hF, 1);
    repeat (30) cyc();
    check("bp_strobes", 64'(got_s.size()), 4);
    check("bp_readcol", 64'(ReadCol), 0);
    check("bp_busy", 64'(Busy), 1);
    check("bp_valid", 64'(DataValid), 1);
    DataReady = 1;
    wait_idle(100);
    cmp_strobes();
    Freeze = 0;
    cyc();

    drain();
    h = '{2, 0, 0, 1};
    start_frame(4'b0111, 1);
    ColEnable[3] = 0;
    h[2] = 1;
    upd();
    Freeze = 0;
    cyc();
    Freeze = 1;
    cyc();
    wait_idle(100);
    cmp_strobes();
    repeat (3) cyc();
    check("ignored_rise", 64'(Busy), 0);
    Freeze = 0;
    cyc();
    start_frame(4'hF, 1);
    wait_idle(100);
    cmp_strobes();
    Freeze = 0;
    cyc();

    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < NCOL; i++) h[i] = $urandom_range(0, 3);
      ColEnable = NCOL'($urandom_range(0, 15));
      rnd_ready = 1;
      start_frame(4'hF, 1);
      wait_idle(300);
      cmp_strobes();
      Freeze = 0;
      cyc();
    end

    drain();
    repeat (3) cyc();
    check("end_empty", 64'(DataValid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
